// File: rtl/feeder_pkg.sv
// Shared state encoding, default widths and start-pulse length for sample_feeder.
package feeder_pkg;
  localparam int DEPTH_DEF    = 51;
  localparam int X_W_DEF      = 7;
  localparam int T_W_DEF      = 2;
  localparam int N_W_DEF      = 32;
  localparam int E_W_DEF      = 8;
  localparam int START_CYCLES = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    FEED   = 2'd2,
    FINISH = 2'd3
  } state_t;
endpackage

// File: rtl/sample_feeder_if.sv
// Feeder-to-neuron link: start handshake, sample/target/parameter buses and the neuron's done.
interface sample_feeder_if
  import feeder_pkg::*;
#(
  parameter int X_W = X_W_DEF,
  parameter int T_W = T_W_DEF,
  parameter int N_W = N_W_DEF
) ();
  logic           start;
  logic [X_W-1:0] X1Bus;
  logic [X_W-1:0] X2Bus;
  logic [T_W-1:0] tBus;
  logic [N_W-1:0] nBus;
  logic           neuron_done;

  modport master (output start, X1Bus, X2Bus, tBus, nBus, input neuron_done);
  modport slave  (input start, X1Bus, X2Bus, tBus, nBus, output neuron_done);
endinterface

// File: rtl/sample_ram.sv
// Sample register file: one synchronous write port, one asynchronous read port, storage not reset.
module sample_ram #(
  parameter int DEPTH = 51,
  parameter int W     = 16,
  parameter int AW    = 6
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);
  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/sample_feeder.sv
// Buffers labelled samples and streams them to the neuron epoch after epoch until done or the epoch limit.
// Build option FEEDER_ROTATE_EN: each epoch starts at index (epoch mod count) instead of index 0.
module sample_feeder
  import feeder_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int X_W   = X_W_DEF,
  parameter int T_W   = T_W_DEF,
  parameter int N_W   = N_W_DEF,
  parameter int E_W   = E_W_DEF,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [X_W-1:0]  wr_x1,
  input  logic [X_W-1:0]  wr_x2,
  input  logic [T_W-1:0]  wr_t,
  input  logic            clear,
  input  logic            go,
  input  logic [N_W-1:0]  n_cfg,
  input  logic [E_W-1:0]  max_epochs,
  sample_feeder_if.master nrn,
  output logic            busy,
  output logic            finished,
  output logic [CW-1:0]   count,
  output logic            full,
  output logic [E_W-1:0]  epoch
);
  localparam int SW = 2 * X_W + T_W;
  localparam logic [CW-1:0] ONE = CW'(1);

  state_t         r_state;
  logic [1:0]     r_scnt;
  logic [CW-1:0]  r_count;
  logic [CW-1:0]  r_idx;
  logic [CW-1:0]  r_pos;
  logic [E_W-1:0] r_epoch;
  logic           r_start;
  logic           r_finished;
  logic [X_W-1:0] r_x1;
  logic [X_W-1:0] r_x2;
  logic [T_W-1:0] r_t;
  logic [N_W-1:0] r_n;

  logic           w_full;
  logic           w_we;
  logic           w_last;
  logic           w_stop;
  logic [E_W-1:0] w_ep_inc;
  logic [CW-1:0]  w_idx_inc;
  logic [CW-1:0]  w_base_nxt;
  logic [CW-1:0]  w_rd_addr;
  logic [SW-1:0]  w_rd_data;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_we      = (r_state == IDLE) && wr_en && !clear && !w_full;
  assign w_last    = (r_pos == r_count - ONE);
  assign w_ep_inc  = (&r_epoch) ? r_epoch : r_epoch + E_W'(1);
  assign w_stop    = (max_epochs != '0) && (w_ep_inc == max_epochs);
  assign w_idx_inc = (r_idx == r_count - ONE) ? '0 : r_idx + ONE;

`ifdef FEEDER_ROTATE_EN
  // r_base tracks epoch mod count; it freezes once the epoch counter saturates.
  logic [CW-1:0] r_base;
  assign w_base_nxt = (&r_epoch) ? r_base : ((r_base == r_count - ONE) ? '0 : r_base + ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       r_base <= '0;
    else if (r_state == IDLE && go)                   r_base <= '0;
    else if (r_state == FEED && !nrn.neuron_done && w_last) r_base <= w_base_nxt;
  end
`else
  assign w_base_nxt = '0;
`endif

  // Address of the sample to present on the next edge; START always leads into index 0.
  assign w_rd_addr = (r_state == FEED) ? (w_last ? w_base_nxt : w_idx_inc) : '0;

  sample_ram #(.DEPTH(DEPTH), .W(SW), .AW(CW)) u_ram (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_waddr (r_count),
    .i_wdata ({wr_x1, wr_x2, wr_t}),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_scnt     <= '0;
      r_count    <= '0;
      r_idx      <= '0;
      r_pos      <= '0;
      r_epoch    <= '0;
      r_start    <= 1'b0;
      r_finished <= 1'b0;
      r_x1       <= '0;
      r_x2       <= '0;
      r_t        <= '0;
      r_n        <= '0;
    end else begin
      r_finished <= 1'b0;
      case (r_state)
        IDLE: begin
          if (clear)     r_count <= '0;
          else if (w_we) r_count <= r_count + ONE;
          if (go) begin
            r_epoch <= '0;
            if (r_count == '0) begin
              r_finished <= 1'b1;
              r_state    <= FINISH;
            end else begin
              r_n     <= n_cfg;
              r_idx   <= '0;
              r_pos   <= '0;
              r_scnt  <= '0;
              r_start <= 1'b1;
              r_state <= START;
            end
          end
        end
        START: begin
          if (r_scnt == 2'(START_CYCLES - 1)) begin
            r_start            <= 1'b0;
            {r_x1, r_x2, r_t}  <= w_rd_data;
            r_idx              <= '0;
            r_pos              <= '0;
            r_state            <= FEED;
          end else begin
            r_scnt <= r_scnt + 2'd1;
          end
        end
        FEED: begin
          if (nrn.neuron_done || (w_last && w_stop)) begin
            if (!nrn.neuron_done) r_epoch <= w_ep_inc;
            {r_x1, r_x2, r_t} <= '0;
            r_finished        <= 1'b1;
            r_state           <= FINISH;
          end else begin
            {r_x1, r_x2, r_t} <= w_rd_data;
            if (w_last) begin
              r_epoch <= w_ep_inc;
              r_idx   <= w_base_nxt;
              r_pos   <= '0;
            end else begin
              r_idx   <= w_idx_inc;
              r_pos   <= r_pos + ONE;
            end
          end
        end
        FINISH:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign nrn.start = r_start;
  assign nrn.X1Bus = r_x1;
  assign nrn.X2Bus = r_x2;
  assign nrn.tBus  = r_t;
  assign nrn.nBus  = r_n;
  assign busy      = (r_state != IDLE);
  assign finished  = r_finished;
  assign count     = r_count;
  assign full      = w_full;
  assign epoch     = r_epoch;
endmodule

// File: tb/tb_sample_feeder.sv
// Scoreboard bench for sample_feeder: a run-level model queues the expected per-cycle output stream.
module tb_sample_feeder;
  localparam int DEPTH = 51;
  localparam int X_W   = 7;
  localparam int T_W   = 2;
  localparam int N_W   = 32;
  localparam int E_W   = 8;
  localparam int CW    = 6;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           wr_en = 1'b0;
  logic           clear = 1'b0;
  logic           go = 1'b0;
  logic [X_W-1:0] wr_x1 = '0;
  logic [X_W-1:0] wr_x2 = '0;
  logic [T_W-1:0] wr_t = '0;
  logic [N_W-1:0] n_cfg = '0;
  logic [E_W-1:0] max_epochs = '0;
  logic           busy, finished, full;
  logic [CW-1:0]  count;
  logic [E_W-1:0] epoch;

  sample_feeder_if #(.X_W(X_W), .T_W(T_W), .N_W(N_W)) nif ();

  sample_feeder #(.DEPTH(DEPTH), .X_W(X_W), .T_W(T_W), .N_W(N_W), .E_W(E_W)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_x1(wr_x1), .wr_x2(wr_x2), .wr_t(wr_t),
    .clear(clear), .go(go), .n_cfg(n_cfg), .max_epochs(max_epochs), .nrn(nif),
    .busy(busy), .finished(finished), .count(count), .full(full), .epoch(epoch)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [63:0] q [$];
  logic [15:0] mdl [DEPTH];
  int          mcount = 0;
  logic [31:0] last_n = '0;
  logic [7:0]  exp_ep = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Event kinds: 1 = start cycle, 2 = sample cycle, 3 = finished cycle.
  function automatic logic [63:0] ev(input logic [1:0] k, input logic [15:0] s,
                                     input logic [31:0] n, input logic [7:0] ep);
    return {6'd0, k, s, n, ep};
  endfunction

  always @(negedge clk) begin : monitor
    logic [1:0]  k;
    logic [63:0] act;
    if (rst_n) begin
      if (busy) begin
        k   = nif.start ? 2'd1 : (finished ? 2'd3 : 2'd2);
        act = ev(k, {nif.X1Bus, nif.X2Bus, nif.tBus}, nif.nBus, finished ? epoch : 8'd0);
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %h expected none", act);
        end else begin
          chk("stream", act, q.pop_front());
        end
      end else if (nif.start || finished) begin
        checks++;
        errors++;
        $display("FAIL idle_output: got start=%0b finished=%0b expected 0", nif.start, finished);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [6:0] a, input logic [6:0] b, input logic [1:0] t);
    wr_x1 = a; wr_x2 = b; wr_t = t; wr_en = 1'b1;
    tick;
    wr_en = 1'b0;
    if (mcount < DEPTH) begin
      mdl[mcount] = {a, b, t};
      mcount++;
    end
  endtask

  task automatic wr_rand;
    wr(7'($urandom), 7'($urandom), 2'($urandom));
  endtask

  task automatic clr;
    clear = 1'b1;
    tick;
    clear = 1'b0;
    mcount = 0;
  endtask

  // Queue the whole expected run from the sample list, then issue go (and done at sample D if D >= 0).
  task automatic start_run(input logic [31:0] n, input int m, input int d, input bit noise);
    int  s = 0;
    int  ticks = 0;
    bit  stop = 0;
    max_epochs = 8'(m);
    n_cfg = n;
    exp_ep = 8'd0;
    if (mcount == 0) begin
      q.push_back(ev(2'd3, 16'd0, last_n, 8'd0));
    end else begin
      last_n = n;
      repeat (2) q.push_back(ev(2'd1, 16'd0, n, 8'd0));
      for (int e = 0; e < 300 && !stop; e++) begin
        for (int p = 0; p < mcount && !stop; p++) begin
          int idx;
`ifdef FEEDER_ROTATE_EN
          idx = ((e % mcount) + p) % mcount;
`else
          idx = p;
`endif
          q.push_back(ev(2'd2, mdl[idx], n, 8'd0));
          if (d >= 0 && s == d) begin
            exp_ep = 8'(e);
            q.push_back(ev(2'd3, 16'd0, n, exp_ep));
            stop = 1;
          end
          s++;
        end
        if (!stop && m != 0 && e + 1 == m) begin
          exp_ep = 8'(e + 1);
          q.push_back(ev(2'd3, 16'd0, n, exp_ep));
          stop = 1;
        end
      end
    end
    go = 1'b1;
    tick;
    go = 1'b0;
    if (noise) begin
      wr_en = 1'b1; clear = 1'b1; go = 1'b1; nif.neuron_done = 1'b1;
      tick;
      ticks++;
      wr_en = 1'b0; clear = 1'b0; go = 1'b0; nif.neuron_done = 1'b0;
    end
    if (d >= 0) begin
      while (ticks < 2 + d) begin
        tick;
        ticks++;
      end
      nif.neuron_done = 1'b1;
      tick;
      nif.neuron_done = 1'b0;
    end
  endtask

  task automatic finish_run(input string name);
    int t = 0;
    while (busy && t < 3000) begin
      tick;
      t++;
    end
    chk({name, "_busy_end"}, 64'(busy), 64'd0);
    chk({name, "_drain"}, 64'(q.size()), 64'd0);
    chk({name, "_epoch"}, 64'(epoch), 64'(exp_ep));
    chk({name, "_count"}, 64'(count), 64'(mcount));
  endtask

  task automatic chk_reset_state(input string name);
    chk({name, "_bus"}, 64'({nif.start, nif.X1Bus, nif.X2Bus, nif.tBus, nif.nBus}), 64'd0);
    chk({name, "_ctl"}, 64'({busy, finished, count, epoch, full}), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    nif.neuron_done = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk_reset_state("reset");
    rst_n = 1'b1;
    tick;

    // Single sample, three epochs.
    wr(7'b1110000, 7'b1110000, 2'b11);
    chk("count_one", 64'(count), 64'd1);
    start_run(32'd5, 3, -1, 0);
    finish_run("single");

    // Three samples, done on the second sample of epoch 1, with ignored inputs during START.
    clr;
    repeat (3) wr_rand;
    start_run($urandom, 0, 4, 1);
    finish_run("done_early");

    for (int r = 0; r < 8; r++) begin
      int c, m, d, total;
      if ($urandom_range(0, 1) != 0) clr;
      repeat ($urandom_range(1, 5)) wr_rand;
      c = mcount;
      m = int'($urandom_range(0, 3));
      d = -1;
      if (c == 1 && m == 0) m = 2;
      if (c > 1 && (m == 0 || $urandom_range(0, 1) != 0)) begin
        total = ((m == 0) ? 3 : m) * c;
        do d = int'($urandom_range(0, total - 1)); while (d % c == c - 1);
      end
      start_run($urandom, m, d, bit'($urandom_range(0, 1)));
      finish_run("random");
    end

    // Fill past capacity; the 52nd write must be dropped.
    clr;
    repeat (52) wr_rand;
    chk("count_full", 64'(count), 64'(DEPTH));
    chk("full_flag", 64'(full), 64'd1);
    start_run($urandom, 1, -1, 0);
    finish_run("full_run");

    clear = 1'b1; wr_en = 1'b1;
    tick;
    clear = 1'b0; wr_en = 1'b0;
    mcount = 0;
    chk("clear_beats_wr", 64'(count), 64'd0);
    chk("full_cleared", 64'(full), 64'd0);

    // Empty buffer: go finishes immediately without a start pulse.
    start_run($urandom, 2, -1, 1);
    finish_run("empty_go");

    // Asynchronous reset in the middle of FEED.
    repeat (4) wr_rand;
    start_run($urandom, 2, -1, 0);
    repeat (4) tick;
    #1 rst_n = 1'b0;
    #1;
    q.delete();
    mcount = 0;
    last_n = '0;
    chk_reset_state("mid_reset");
    tick;
    rst_n = 1'b1;
    tick;
    start_run($urandom, 1, -1, 0);
    finish_run("post_reset_go");

    // Three named samples over three epochs (rotation order when enabled).
    clr;
    wr(7'h0A, 7'h01, 2'd1);
    wr(7'h0B, 7'h02, 2'd2);
    wr(7'h0C, 7'h03, 2'd3);
    start_run(32'd9, 3, -1, 0);
    finish_run("abc");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sample_feeder.md
# sample_feeder

Training-sample sequencer sitting directly upstream of the neuron training module. It buffers up to DEPTH labelled samples (X1, X2, target t), then on `go` pulses the neuron's start handshake, presents the run parameter n, and streams samples one per clock, epoch after epoch. It stops when the neuron reports `done` or an epoch limit is reached. It owns the neuron's `X1Bus`/`X2Bus`/`tBus`/`nBus`/`start` inputs.

## Interface
- DEPTH, 51: sample buffer entries (index width CW = clog2(DEPTH+1)).
- X_W, 7: sample component width.
- T_W, 2: target width.
- N_W, 32: run parameter width.
- E_W, 8: epoch counter width.
- Clock and reset: one clock, `clk`; reset `rst_n` is asynchronous and active-low.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- wr_en  in  1  append sample (IDLE only)
- wr_x1, wr_x2  in  X_W  sample components
- wr_t  in  T_W  sample target
- clear  in  1  empty buffer (IDLE only)
- go  in  1  begin run (IDLE only)
- n_cfg  in  N_W  run parameter, latched on go
- max_epochs  in  E_W  epoch limit, 0 = unlimited
- neuron_done  in  1  neuron's done
- start  out  1  neuron start
- X1Bus, X2Bus  out  X_W  sample to neuron
- tBus  out  T_W  target to neuron
- nBus  out  N_W  latched n_cfg
- busy  out  1  state ≠ IDLE
- finished  out  1  one-cycle end-of-run pulse
- count  out  CW  stored samples
- full  out  1  count == DEPTH
- epoch  out  E_W  completed epochs of current/last run

## Operation
- States: IDLE, START, FEED, FINISH.
- IDLE:
  - wr_en && !full writes entry [count], count+1.
  - wr_en when full is ignored.
  - clear sets count=0; clear beats wr_en in the same cycle.
  - go with count==0 → FINISH directly (epoch=0, start never asserted).
  - go with count>0 → latch n_cfg into nBus, epoch=0, idx=0, → START.
- START:
  - start=1 for exactly 2 cycles; nBus valid from the first.
  - X/t buses are 0.
  - Then → FEED.
- FEED:
  - start=0; each cycle drive entry[idx] on X1Bus/X2Bus/tBus.
  - idx wraps count-1→0 and epoch+1 (saturates at all-ones).
  - If the wrap makes epoch == max_epochs (max_epochs≠0) → FINISH.
  - neuron_done=1 in any FEED cycle → FINISH next edge; the current sample is the last presented.
  - neuron_done is ignored in IDLE/START.
- FINISH: finished=1 for one cycle, buses cleared to 0 (nBus holds), → IDLE.
- go/wr_en/clear outside IDLE are ignored.
- Buffer contents persist across runs; only count is cleared by clear or reset.

## Timing
- Reset (async assert, sync release) → IDLE:
  - start=0; all buses 0; busy=0; finished=0; count=0; epoch=0; full=0.
  - Reset mid-run aborts immediately with the same values.
- go at edge k: start=1 in cycles k+1, k+2; first sample in cycle k+3.
- Sample i of epoch e is presented in cycle k+3+e·count+i.
- All outputs are registered; no combinational input→output path.
- Run of E full epochs: finished at cycle k+3+E·count; busy is low the cycle after.

## Configuration
- Macro FEEDER_ROTATE_EN:
  - Defined: each epoch starts at index (epoch mod count) and presents count samples cyclically. This decorrelates order for the perceptron.
  - Undefined: every epoch starts at index 0.
  - Epoch/termination rules are identical either way.

## Structure
- Package feeder_pkg: state enum (IDLE/START/FEED/FINISH), default widths X_W/T_W/N_W/E_W, START_CYCLES=2.
- Sub-module sample_ram: DEPTH × (2·X_W+T_W) register file, one sync write port, one async read port, no reset on storage.

## Test plan
- Load X1=7'b1110000, X2=7'b1110000, t=2'b11 once; go with n_cfg=5, max_epochs=3 → start high 2 cycles with nBus=5, sample on buses 3 consecutive cycles, epoch=3, finished pulse, busy low.
- Load 3 samples; neuron_done asserted in the 2nd FEED cycle of epoch 1 → exactly 5 samples presented, finished next cycle, epoch=1.
- Write 52 samples with DEPTH=51 → count=51, full=1, 52nd write ignored; clear+wr_en same cycle → count=0.
- go with count=0 → finished the next cycle, start never high, epoch=0.
- Deassert rst_n mid-FEED → all outputs 0 asynchronously, count=0; later go without reload finishes immediately.
- With FEEDER_ROTATE_EN, 3 samples A,B,C, max_epochs=3 → order A B C, B C A, C A B.
